// File: rtl/display_scan_pkg.sv
// Shared display codes and sizing helpers for the digit scanner and the
// downstream 7-segment decoder.
package display_scan_pkg;

   localparam logic [3:0] CODE_ZERO  = 4'd0;
   localparam logic [3:0] CODE_DASH  = 4'd10;
   localparam logic [3:0] CODE_L     = 4'd11;
   localparam logic [3:0] CODE_C     = 4'd12;
   localparam logic [3:0] CODE_R     = 4'd13;
   localparam logic [3:0] CODE_E     = 4'd14;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   // Counter must hold 0..max(a,b)-1; never narrower than one bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/display_scan_lz_blank_mask.sv
// Leading-zero blank mask: bit i set when digit i and every more significant
// digit hold code 0. Digit 0 is never blanked.
module lz_blank_mask
   import display_scan_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic [4*DIGITS-1:0] digits,
   input  logic                lz_blank,
   output logic [DIGITS-1:0]   mask
);

   logic all_zero;

   always_comb begin
      mask     = '0;
      all_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         all_zero = all_zero & (digits[4*i +: 4] == CODE_ZERO);
         if (i != 0) mask[i] = lz_blank & all_zero;
      end
   end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scanner for a common-segment multi-digit 7-segment display.
// state | meaning
// GAP   | dead time, decoder deselected, all digit enables low
// SHOW  | digit idx enabled, latched code driven to the decoder
module display_scan
   import display_scan_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1000,
   parameter int GAP_CYC  = 8,
   parameter int AW       = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [3:0]        wr_data,
   input  logic              lz_blank,
   output logic [3:0]        data_out,
   output logic              dec_select,
   output logic [DIGITS-1:0] digit_en
);

   localparam int CW = cnt_width(SCAN_DIV, GAP_CYC);

   localparam logic ST_GAP  = 1'b0;
   localparam logic ST_SHOW = 1'b1;

   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
   localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
   localparam logic [AW-1:0] IDX_LAST  = AW'(DIGITS - 1);

   logic                     state;
   logic [CW-1:0]            cnt;
   logic [AW-1:0]            idx;
   logic [DIGITS-1:0][3:0]   store;
   logic [DIGITS-1:0]        mask;
   logic [3:0]               eff_code;

   lz_blank_mask #(.DIGITS(DIGITS)) u_lz_blank_mask (
      .digits   (store),
      .lz_blank (lz_blank),
      .mask     (mask)
   );

   // Effective code of the digit about to be shown, sampled from the store
   // as it stands before any write on the same edge.
   always_comb begin
      eff_code = CODE_BLANK;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == AW'(i)) eff_code = mask[i] ? CODE_BLANK : store[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         store      <= {DIGITS{CODE_BLANK}};
         state      <= ST_GAP;
         cnt        <= '0;
         idx        <= '0;
         data_out   <= CODE_BLANK;
         dec_select <= 1'b0;
         digit_en   <= '0;
      end else begin
         // Addresses at or above DIGITS match no entry and are dropped.
         if (wr_en) begin
            for (int i = 0; i < DIGITS; i++) begin
               if (wr_addr == AW'(i)) store[i] <= wr_data;
            end
         end

         if (!enable) begin
            state      <= ST_GAP;
            cnt        <= '0;
            data_out   <= CODE_BLANK;
            dec_select <= 1'b0;
            digit_en   <= '0;
         end else begin
            case (state)
               ST_GAP: begin
                  if (cnt == GAP_LAST) begin
                     state      <= ST_SHOW;
                     cnt        <= '0;
                     data_out   <= eff_code;
                     dec_select <= 1'b1;
                     digit_en   <= DIGITS'(1) << idx;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: begin
                  if (cnt == SHOW_LAST) begin
                     state      <= ST_GAP;
                     cnt        <= '0;
                     idx        <= (idx == IDX_LAST) ? '0 : idx + AW'(1);
                     data_out   <= CODE_BLANK;
                     dec_select <= 1'b0;
                     digit_en   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: a slot-position reference model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_display_scan;

   localparam int D  = 4;
   localparam int SD = 4;
   localparam int GC = 2;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [3:0]    wr_data = '0;
   logic          lz_blank = 1'b0;
   logic [3:0]    data_out;
   logic          dec_select;
   logic [D-1:0]  digit_en;

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   display_scan #(.DIGITS(D), .SCAN_DIV(SD), .GAP_CYC(GC), .AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .lz_blank   (lz_blank),
      .data_out   (data_out),
      .dec_select (dec_select),
      .digit_en   (digit_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position within the current digit period
   // (0..GC+SD-1, show when >= GC), the digit index and the code shown.
   int m_store [D];
   int m_pos = 0;
   int m_idx = 0;
   int m_code = 15;

   function automatic int eff(input int i);
      if (!lz_blank || i == 0) return m_store[i];
      for (int j = i; j < D; j++) if (m_store[j] != 0) return m_store[i];
      return 15;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < D; i++) m_store[i] = 15;
         m_pos  = 0;
         m_idx  = 0;
         m_code = 15;
      end else begin
         if (!enable) begin
            m_pos = 0;
         end else begin
            m_pos++;
            if (m_pos == GC) m_code = eff(m_idx);
            if (m_pos == GC + SD) begin
               m_pos = 0;
               m_idx = (m_idx + 1) % D;
            end
         end
         if (wr_en && int'(wr_addr) < D) m_store[wr_addr] = int'(wr_data);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         if (m_pos >= GC) begin
            check("model_sel",  int'(dec_select), 1);
            check("model_en",   int'(digit_en),   1 << m_idx);
            check("model_data", int'(data_out),   m_code);
         end else begin
            check("model_sel",  int'(dec_select), 0);
            check("model_en",   int'(digit_en),   0);
            check("model_data", int'(data_out),   15);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_write(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = 4'(d);
      tick(1);
      wr_en   = 1'b0;
   endtask

   task automatic wait_en(input int v, input int budget);
      int n;
      n = 0;
      while (int'(digit_en) != v && n < budget) begin
         tick(1);
         n++;
      end
      if (int'(digit_en) != v) check("wait_digit_en_timeout", int'(digit_en), v);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      enable = 1'b0;
      tick(1);
      reset  = 1'b0;
   endtask

   // Enable from a fresh GAP at idx 0 and check one full frame of codes.
   task automatic frame_check(input string tag, input int c0, input int c1,
                              input int c2, input int c3);
      int codes [4];
      codes = '{c0, c1, c2, c3};
      enable = 1'b1;
      tick(GC);
      for (int i = 0; i < D; i++) begin
         check({tag, "_en"},   int'(digit_en), 1 << i);
         check({tag, "_data"}, int'(data_out), codes[i]);
         tick(SD);
         check({tag, "_gap"},  int'(digit_en), 0);
         tick(GC);
      end
   endtask

   initial begin
      reset = 1'b1;
      tick(3);
      chk_on = 1'b1;
      check("rst_data", int'(data_out), 15);
      check("rst_sel",  int'(dec_select), 0);
      check("rst_en",   int'(digit_en), 0);

      // Power-up scan, empty store.
      reset  = 1'b0;
      enable = 1'b1;
      tick(1);
      check("gap0_sel", int'(dec_select), 0);
      tick(1);
      check("show0_sel",  int'(dec_select), 1);
      check("show0_en",   int'(digit_en), 1);
      check("show0_data", int'(data_out), 15);
      tick(SD);
      check("gap1_en", int'(digit_en), 0);
      tick(GC);
      check("show1_en", int'(digit_en), 2);
      tick(3 * (GC + SD));
      check("wrap_en", int'(digit_en), 1);

      // Plain digits.
      do_reset();
      do_write(0, 1); do_write(1, 2); do_write(2, 3); do_write(3, 4);
      frame_check("digits", 1, 2, 3, 4);

      // Leading-zero blanking.
      do_reset();
      lz_blank = 1'b1;
      do_write(0, 0); do_write(1, 7); do_write(2, 0); do_write(3, 0);
      frame_check("lz_0070", 0, 7, 15, 15);
      do_reset();
      do_write(0, 0); do_write(1, 0); do_write(2, 0); do_write(3, 0);
      frame_check("lz_zero", 0, 15, 15, 15);
      do_reset();
      do_write(0, 0); do_write(1, 0); do_write(2, 0); do_write(3, 14);
      frame_check("lz_e", 0, 0, 0, 14);
      lz_blank = 1'b0;

      // Write during SHOW, and an out-of-range write.
      do_reset();
      do_write(0, 1); do_write(1, 2); do_write(2, 5); do_write(3, 4);
      enable = 1'b1;
      wait_en(4, 40);
      check("wshow_old", int'(data_out), 5);
      do_write(2, 9);
      check("wshow_hold", int'(data_out), 5);
      do_write(5, 3);
      check("wshow_hold2", int'(data_out), 5);
      wait_en(0, 20);
      wait_en(2, 40);
      check("wignore_d1", int'(data_out), 2);
      wait_en(4, 40);
      check("wshow_new", int'(data_out), 9);

      // Enable drop in SHOW of idx 2, then resume at idx 2.
      enable = 1'b0;
      tick(1);
      check("dis_sel", int'(dec_select), 0);
      check("dis_en",  int'(digit_en), 0);
      tick(3);
      enable = 1'b1;
      tick(1);
      check("reen_gap", int'(digit_en), 0);
      tick(1);
      check("reen_en", int'(digit_en), 4);
      check("reen_data", int'(data_out), 9);

      // Reset mid-SHOW.
      wait_en(8, 40);
      reset = 1'b1;
      tick(1);
      check("mrst_data", int'(data_out), 15);
      check("mrst_sel",  int'(dec_select), 0);
      check("mrst_en",   int'(digit_en), 0);
      reset = 1'b0;
      enable = 1'b1;
      tick(GC);
      check("mrst_show_en",   int'(digit_en), 1);
      check("mrst_show_data", int'(data_out), 15);

      // Randomized traffic checked by the model.
      for (int c = 0; c < 3000; c++) begin
         wr_en    = ($urandom_range(0, 3) == 0);
         wr_addr  = AW'($urandom_range(0, 7));
         wr_data  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 40) == 0) lz_blank = ~lz_blank;
         enable   = ($urandom_range(0, 60) != 0);
         reset    = ($urandom_range(0, 400) == 0);
         tick(1);
      end
      reset = 1'b0;
      wr_en = 1'b0;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
